// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks destination/Tnew of in-flight instructions, raises stall,
// picks forwarding sources, and counts down the multiply/divide busy window.
module hazard_scoreboard #(
    parameter int STAGES  = 3,
    parameter int TNEW_W  = 3,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10,
    parameter int SEL_W   = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic              d_wr_en,
    input  logic [4:0]        d_wr_addr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_mdu_start,
    input  logic              d_mdu_div,
    input  logic              d_mdu_use,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_rs,
    output logic [SEL_W-1:0]  fwd_sel_rt,
    output logic              mdu_busy
);

    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [STAGES:1]   st_valid;
    logic [4:0]        st_addr [1:STAGES];
    logic [TNEW_W-1:0] st_tnew [1:STAGES];
    logic [CNT_W-1:0]  mdu_cnt;

    logic              hit_rs, hit_rt;
    logic [TNEW_W-1:0] hit_tnew_rs, hit_tnew_rt;
    logic [SEL_W-1:0]  hit_k_rs, hit_k_rt;
    logic              stall_rs, stall_rt, stall_mdu;
    logic              accept;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit_rs      = 1'b0;
        hit_rt      = 1'b0;
        hit_tnew_rs = '0;
        hit_tnew_rt = '0;
        hit_k_rs    = '0;
        hit_k_rt    = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (st_valid[k] && (st_addr[k] == d_rs) && (st_addr[k] != 5'd0)) begin
                hit_rs      = 1'b1;
                hit_tnew_rs = st_tnew[k];
                hit_k_rs    = SEL_W'(k);
            end
            if (st_valid[k] && (st_addr[k] == d_rt) && (st_addr[k] != 5'd0)) begin
                hit_rt      = 1'b1;
                hit_tnew_rt = st_tnew[k];
                hit_k_rt    = SEL_W'(k);
            end
        end
    end

    always_comb begin
        stall_rs   = hit_rs && (hit_tnew_rs > d_tuse_rs);
        stall_rt   = hit_rt && (hit_tnew_rt > d_tuse_rt);
        stall_mdu  = d_mdu_use && mdu_busy;
        stall      = !flush && (stall_rs || stall_rt || stall_mdu);
        accept     = !stall && !flush;
        fwd_sel_rs = (hit_rs && (hit_tnew_rs == '0)) ? hit_k_rs : '0;
        fwd_sel_rt = (hit_rt && (hit_tnew_rt == '0)) ? hit_k_rt : '0;
        mdu_busy   = (mdu_cnt != '0);
    end

    // Stages never freeze: a stall or flush only injects a bubble into stage 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_valid <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                st_addr[k] <= '0;
                st_tnew[k] <= '0;
            end
        end else begin
            st_valid[1] <= d_wr_en && accept;
            st_addr[1]  <= d_wr_addr;
            st_tnew[1]  <= d_tnew;
            for (int k = 2; k <= STAGES; k++) begin
                st_valid[k] <= st_valid[k-1] && !flush;
                st_addr[k]  <= st_addr[k-1];
                st_tnew[k]  <= (st_tnew[k-1] == '0) ? '0 : st_tnew[k-1] - TNEW_W'(1);
            end
        end
    end

    // A started MDU operation runs to completion even across a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_cnt <= '0;
        end else if (d_mdu_start && accept) begin
            mdu_cnt <= d_mdu_div ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: per-scenario tasks push expected {stall, fwd_rs, fwd_rt, busy}
// words into a queue and pop them against the DUT at the falling edge.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_wr_en, d_mdu_start, d_mdu_div, d_mdu_use, flush;
    logic       stall, mdu_busy;
    logic [1:0] fwd_sel_rs, fwd_sel_rt;

    logic [5:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
        .d_mdu_start(d_mdu_start), .d_mdu_div(d_mdu_div), .d_mdu_use(d_mdu_use),
        .flush(flush), .stall(stall),
        .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .mdu_busy(mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_d(input logic [4:0] rs, input logic [2:0] tu_rs,
                         input logic [4:0] rt, input logic [2:0] tu_rt,
                         input logic we, input logic [4:0] wa, input logic [2:0] tn,
                         input logic ms, input logic md, input logic mu, input logic fl);
        d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
        d_wr_en = we; d_wr_addr = wa; d_tnew = tn;
        d_mdu_start = ms; d_mdu_div = md; d_mdu_use = mu; flush = fl;
    endtask

    task automatic set_nop();
        set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Empties all stages and lets any MDU count expire.
    task automatic drain();
        set_nop();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got, exp;
        for (int i = 0; i < 2; i++) begin
            set_nop();
            exp_q.push_back(6'b0_00_00_0);
            @(negedge clk);
            got = {stall, fwd_sel_rs, fwd_sel_rt, mdu_busy};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%b exp=%b", i, got, exp);
            end
            @(posedge clk); #1;
            reset = 1'b1;
        end
    endtask

    task automatic test_load_use();
        logic [5:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b1, 5'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                         exp_q.push_back(6'b0_00_00_0); end
                1: begin set_d(5'd5, 3'd1, 5'd0, 3'd1, 1'b1, 5'd6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
                         exp_q.push_back(6'b1_00_00_0); end
                2: begin exp_q.push_back(6'b0_00_00_0); end
                default: begin set_d(5'd5, 3'd1, 5'd9, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                         exp_q.push_back(6'b0_11_00_0); end
            endcase
            @(negedge clk);
            got = {stall, fwd_sel_rs, fwd_sel_rt, mdu_busy};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, got, exp);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_branch();
        logic [5:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b1, 5'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
                         exp_q.push_back(6'b0_00_00_0); end
                1: begin set_d(5'd3, 3'd0, 5'd3, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                         exp_q.push_back(6'b1_00_00_0); end
                default: exp_q.push_back(6'b0_10_10_0);
            endcase
            @(negedge clk);
            got = {stall, fwd_sel_rs, fwd_sel_rt, mdu_busy};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL branch[%0d] got=%b exp=%b", i, got, exp);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_zero_shadow();
        logic [5:0] got, exp;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                set_d(5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 5'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                exp_q.push_back(6'b0_00_00_0);
            end else if (i == 4) begin
                set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b1, 5'd4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                exp_q.push_back(6'b0_00_00_0);
            end else if (i == 5) begin
                set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b1, 5'd4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                exp_q.push_back(6'b0_00_00_0);
            end else begin
                set_d(5'd4, 3'd0, 5'd4, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                exp_q.push_back(6'b0_01_01_0);
            end
            @(negedge clk);
            got = {stall, fwd_sel_rs, fwd_sel_rt, mdu_busy};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL zero_shadow[%0d] got=%b exp=%b", i, got, exp);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_mdu();
        logic [5:0] got, exp;
        for (int i = 0; i < 19; i++) begin
            if (i == 0) begin
                set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
                exp_q.push_back(6'b0_00_00_0);
            end else if (i <= 6) begin
                set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                exp_q.push_back((i <= 5) ? 6'b1_00_00_1 : 6'b0_00_00_0);
            end else if (i == 7) begin
                set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
                exp_q.push_back(6'b0_00_00_0);
            end else begin
                set_nop();
                exp_q.push_back((i <= 17) ? 6'b0_00_00_1 : 6'b0_00_00_0);
            end
            @(negedge clk);
            got = {stall, fwd_sel_rs, fwd_sel_rt, mdu_busy};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mdu[%0d] got=%b exp=%b", i, got, exp);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_flush();
        logic [5:0] got, exp;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
                         exp_q.push_back(6'b0_00_00_0); end
                1: begin set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b1, 5'd7, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                         exp_q.push_back(6'b0_00_00_1); end
                2: begin set_d(5'd7, 3'd1, 5'd0, 3'd6, 1'b1, 5'd8, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
                         exp_q.push_back(6'b0_00_00_1); end
                default: begin
                    set_d(5'd7, 3'd0, 5'd7, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                    exp_q.push_back((i <= 5) ? 6'b0_00_00_1 : 6'b0_00_00_0);
                end
            endcase
            @(negedge clk);
            got = {stall, fwd_sel_rs, fwd_sel_rt, mdu_busy};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flush[%0d] got=%b exp=%b", i, got, exp);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_async_reset();
        logic [5:0] got, exp;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
                         exp_q.push_back(6'b0_00_00_0); end
                1: begin set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
                         exp_q.push_back(6'b0_00_00_1); end
                2: begin set_d(5'd0, 3'd6, 5'd0, 3'd6, 1'b1, 5'd10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                         exp_q.push_back(6'b0_00_00_1); end
                3: begin set_d(5'd10, 3'd0, 5'd9, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                         exp_q.push_back(6'b1_00_10_1); end
                default: exp_q.push_back(6'b0_00_00_0);
            endcase
            if (i == 4) begin
                #2 reset = 1'b0;
                #1;
            end else begin
                @(negedge clk);
            end
            got = {stall, fwd_sel_rs, fwd_sel_rt, mdu_busy};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL async_reset[%0d] got=%b exp=%b", i, got, exp);
            end
            if (i != 3) begin
                @(posedge clk); #1;
            end
            if (i == 4) reset = 1'b1;
        end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        set_nop();
        test_reset();
        test_load_use();
        test_branch();
        test_zero_shadow();
        test_mdu();
        test_flush();
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the pipelined MIPS core. It tracks the destination register and remaining result latency (Tnew) of every in-flight instruction across `STAGES` pipeline stages after decode, and compares them with the Tuse values of the instruction in D. From that comparison it raises `stall` and selects the D-stage forwarding source. It also owns the multiply/divide busy counter and stalls HI/LO users while the MDU is running. It sits beside the D-stage decoder, which feeds it Tuse, Tnew and destination information.

## Interface
Parameters:
- `STAGES`, 3: number of tracked stages after D (1 = E, 2 = M, 3 = W); must be at least 2.
- `TNEW_W`, 3: width of Tuse and Tnew fields.
- `MUL_CYC`, 5: busy cycles for mult/multu.
- `DIV_CYC`, 10: busy cycles for div/divu.
- `SEL_W`, $clog2(STAGES+1): width of the forward select.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `d_rs`, `d_rt` in 5: source register numbers of the D instruction.
- `d_tuse_rs`, `d_tuse_rt` in TNEW_W: cycles until the D instruction needs each operand; 6 means the operand is unused.
- `d_wr_en` in 1: the D instruction writes the GPR file.
- `d_wr_addr` in 5: destination register.
- `d_tnew` in TNEW_W: cycles after entering stage 1 until the result is available.
- `d_mdu_start` in 1: D instruction is mult/multu/div/divu.
- `d_mdu_div` in 1: qualifies `d_mdu_start`; 1 = div/divu.
- `d_mdu_use` in 1: D instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
- `flush` in 1: exception or eret; squashes all tracked stages.
- `stall` out 1: freeze PC and the D register, and insert a bubble into stage 1.
- `fwd_sel_rs`, `fwd_sel_rt` out SEL_W: 0 = use the register file; k = forward from stage k.
- `mdu_busy` out 1: the MDU counter is nonzero.

## Operation
Each stage k (1..STAGES) holds an entry `{valid, addr[4:0], tnew}`.

Advance, every cycle:
- Stage k+1 receives stage k's entry with `tnew` decremented, saturating at 0.
- Stage STAGES's old entry is discarded.
- Stage 1 receives `{d_wr_en, d_wr_addr, d_tnew}` when `stall==0 && flush==0`; otherwise it receives a bubble (valid=0).
- Stages never freeze. A stall only inserts bubbles.

Matching rules:
- Stage k matches rs when valid, `addr==d_rs` and `addr!=0`. The same rule applies to rt.
- The youngest matching stage (lowest k) governs the operand. Older matches are ignored.

Stall and forwarding:
- `stall_rs` = youngest rs match exists and its `tnew > d_tuse_rs`. `stall_rt` is defined the same way.
- `stall_mdu` = `d_mdu_use && mdu_busy`.
- `stall = stall_rs | stall_rt | stall_mdu`, forced to 0 while `flush` is high.
- `fwd_sel_rs` = k when the youngest rs match is stage k and its `tnew==0`; otherwise 0. `fwd_sel_rt` is defined the same way.

MDU counter (width covers max(MUL_CYC, DIV_CYC)):
- Loads MUL_CYC or DIV_CYC when `d_mdu_start && !stall && !flush`.
- Otherwise decrements while nonzero.
- `flush` does not clear the counter: an operation that has already started completes.

Flush: synchronous; every stage entry becomes a bubble on the same edge.

## Timing
- `stall`, `fwd_sel_*` and `mdu_busy` are combinational from state and D inputs; there is no registered output latency.
- State updates on the rising edge of `clk`.
- Reset (asynchronous on `reset==0`): all entries invalid, tnew 0, counter 0. Outputs are therefore `stall=0`, `fwd_sel_*=0`, `mdu_busy=0` regardless of `clk`.
- Reset asserted mid-operation abandons any MDU count and all entries immediately.
- Simultaneous `flush` and stall condition: flush wins, stall=0, no MDU load.
- A D instruction with `d_tuse=6` never stalls on that operand.
- After a mult/multu is accepted, `mdu_busy` is 1 for exactly MUL_CYC cycles. For div/divu it is DIV_CYC cycles.
- A load at the edge wins over a decrement.

## Test plan
- **Load-use:** lw $5 with d_tnew=2 is accepted; next D is addu rs=$5, tuse=1. Required: stall=1 for one cycle. Next cycle, lw sits in stage 2 with tnew=1: stall=0, fwd_sel_rs=0. One cycle later, lw is in stage 3 with tnew=0, so an rs=$5 reader sees fwd_sel_rs=3.
- **Branch after ALU:** addu $3 (d_tnew=1) then beq rs=$3, tuse=0. Required: stall=1 for one cycle, then fwd_sel_rs=2, stall=0.
- **$0 and shadowing:**
  - Writes to $0 in all stages with tnew=2 and rs=$0 give stall=0, fwd_sel_rs=0.
  - lui $4 (tnew 0) in stage 1 with an older lw $4 (tnew 1) in stage 2 gives fwd_sel_rs=1, stall=0.
- **MDU:** mult accepted with MUL_CYC=5, then mfhi in D. Required: mdu_busy=1 and stall=1 for 5 cycles, then stall drops. div with DIV_CYC=10 gives 10 busy cycles.
- **Flush:** lw $7 (tnew 2) in stage 1 and addu rs=$7 in D with flush=1. Required: stall=0 that cycle, all stages bubbles next cycle. An MDU count already in progress keeps decrementing.
- **Async reset:** drop `reset` between edges while stalled and busy. Required: stall, mdu_busy and fwd_sel_* go to 0 immediately, and remain 0 after release until new instructions arrive.
